sram_sp_tiled_sky130: RTL and testbench

SRAM_SP_TILED_SKY130 -- requirements
Module: sram_sp_tiled_sky130

---
 rtl/sram_sp_tiled_sky130.sv | 226 ++++++++++++++++++++++
 tb/tb_sram_sp_tiled_sky130.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sram_sp_tiled_sky130.sv
// sram_sp_tiled_sky130: single-port SRAM built from a grid of 32x128 1RW macros.
// Columns widen the word (DATA_BIT/32), banks deepen it (DEPTH/128).
// Optional per-bit write masking is compiled in with SRAM_SP_TILED_BWE_EN;
// partial masks then run a read-modify-write sequence (IDLE -> RMW_RD -> RMW_WR).
// Without the macro, bwe is ignored and every write is a full-word write.

// Behavioural model of one 32x128 1RW macro: registered read, no reset on contents.
module sram_sp_tiled_sky130_macro (
  input  logic        clk,
  input  logic        cs_i,
  input  logic        we_i,
  input  logic [6:0]  row_i,
  input  logic [31:0] din_i,
  output logic [31:0] dout_o
);

  logic [31:0] mem_q [128];
  logic [31:0] dout_q;

  // Selected macro either writes the row or captures it onto the read port
  always_ff @(posedge clk) begin
    if (cs_i) begin
      if (we_i) begin
        mem_q[row_i] <= din_i;
      end else begin
        dout_q <= mem_q[row_i];
      end
    end
  end

  assign dout_o = dout_q;

endmodule

module sram_sp_tiled_sky130 #(
  parameter int DATA_BIT = 64,
  parameter int DEPTH    = 256,
  parameter int ADDR_BIT = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_BIT-1:0] addr,
  input  logic                wen,
  input  logic                ren,
  input  logic [DATA_BIT-1:0] wdata,
  input  logic [DATA_BIT-1:0] bwe,
  output logic                ready,
  output logic [DATA_BIT-1:0] rdata,
  output logic                rvalid
);

  localparam int NUM_COLS  = DATA_BIT / 32;
  localparam int NUM_BANKS = DEPTH / 128;
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  // Bank index is the address above the 7 row bits
  function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_BIT-1:0] a);
    return BANK_W'(a >> 7);
  endfunction

  // Shared macro access for this cycle (only one bank is ever active)
  logic                acc_cs;
  logic                acc_we;
  logic [BANK_W-1:0]   acc_bank;
  logic [6:0]          acc_row;
  logic [DATA_BIT-1:0] acc_wdata;
  logic                ext_read;

  logic [NUM_BANKS-1:0]         bank_cs;
  logic [NUM_COLS-1:0][31:0]    bank_dout [NUM_BANKS];
  logic [DATA_BIT-1:0]          sel_dout;

  // Read-return pipeline
  logic [BANK_W-1:0]   rd_bank_q, rd_bank_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_BIT-1:0] rdata_q;

  // ---------------------------------------------------------------------------
  // Macro array
  // ---------------------------------------------------------------------------
  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      // Reset deselects everything regardless of what the decode asks for
      assign bank_cs[gi] = acc_cs & ~rst & (acc_bank == BANK_W'(gi));
      for (gj = 0; gj < NUM_COLS; gj++) begin : g_col
        sram_sp_tiled_sky130_macro u_macro (
          .clk    (clk),
          .cs_i   (bank_cs[gi]),
          .we_i   (acc_we),
          .row_i  (acc_row),
          .din_i  (acc_wdata[gj*32 +: 32]),
          .dout_o (bank_dout[gi][gj])
        );
      end
    end
  endgenerate

  // Data from whichever bank was read most recently
  assign sel_dout = bank_dout[rd_bank_q];

`ifdef SRAM_SP_TILED_BWE_EN

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RMW_RD = 2'd1,
    ST_RMW_WR = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_BIT-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_BIT-1:0] lat_wdata_q, lat_wdata_d;
  logic [DATA_BIT-1:0] lat_bwe_q, lat_bwe_d;

  // Request decode and RMW sequencing; partial writes latch their operands
  always_comb begin
    state_d     = state_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_bwe_d   = lat_bwe_q;
    ready       = 1'b0;
    acc_cs      = 1'b0;
    acc_we      = 1'b0;
    acc_bank    = bank_of(addr);
    acc_row     = addr[6:0];
    acc_wdata   = wdata;
    ext_read    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (wen) begin
          if (&bwe) begin
            acc_cs = 1'b1;
            acc_we = 1'b1;
          end else if (|bwe) begin
            state_d     = ST_RMW_RD;
            lat_addr_d  = addr;
            lat_wdata_d = wdata;
            lat_bwe_d   = bwe;
          end
        end else if (ren) begin
          acc_cs   = 1'b1;
          ext_read = 1'b1;
        end
      end
      ST_RMW_RD: begin
        acc_cs   = 1'b1;
        acc_bank = bank_of(lat_addr_q);
        acc_row  = lat_addr_q[6:0];
        state_d  = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        acc_cs    = 1'b1;
        acc_we    = 1'b1;
        acc_bank  = bank_of(lat_addr_q);
        acc_row   = lat_addr_q[6:0];
        acc_wdata = (sel_dout & ~lat_bwe_q) | (lat_wdata_q & lat_bwe_q);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and latched RMW operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_bwe_q   <= '0;
    end else begin
      state_q     <= state_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_bwe_q   <= lat_bwe_d;
    end
  end

`else

  // Per-bit write enable is ignored; every write stores the full word
  logic unused_bwe;
  assign unused_bwe = ^bwe;

  // Every request is single-cycle; write wins over read
  always_comb begin
    ready     = 1'b1;
    acc_cs    = 1'b0;
    acc_we    = 1'b0;
    acc_bank  = bank_of(addr);
    acc_row   = addr[6:0];
    acc_wdata = wdata;
    ext_read  = 1'b0;
    if (wen) begin
      acc_cs = 1'b1;
      acc_we = 1'b1;
    end else if (ren) begin
      acc_cs   = 1'b1;
      ext_read = 1'b1;
    end
  end

`endif

  // Track the bank of every macro read (external or RMW) for the data mux
  assign rd_bank_d = (acc_cs && !acc_we) ? acc_bank : rd_bank_q;
  assign rvalid_d  = ext_read;

  // rdata follows the macro only on rvalid cycles, otherwise it holds
  assign rdata  = rvalid_q ? sel_dout : rdata_q;
  assign rvalid = rvalid_q;

  // Read-return registers; rdata_q keeps the last delivered word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rd_bank_q <= rd_bank_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata;
    end
  end

endmodule

// File: tb/tb_sram_sp_tiled_sky130.sv
// Directed testbench for sram_sp_tiled_sky130 (DATA_BIT=64, DEPTH=256).
// Masked-write scenarios are built when SRAM_SP_TILED_BWE_EN is defined,
// the ignore-mask scenarios otherwise.
module tb_sram_sp_tiled_sky130;

  localparam int DW = 64;
  localparam int DP = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          wen;
  logic          ren;
  logic [DW-1:0] wdata;
  logic [DW-1:0] bwe;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          rvalid;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  sram_sp_tiled_sky130 #(.DATA_BIT(DW), .DEPTH(DP), .ADDR_BIT(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wen    (wen),
    .ren    (ren),
    .wdata  (wdata),
    .bwe    (bwe),
    .ready  (ready),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%016h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] m, input string tag);
    addr = a; wdata = d; bwe = m; wen = 1'b1; ren = 1'b0;
    #1 check_eq({tag, " ready at accept"}, 64'(ready), 64'd1);
    tick();
    wen = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    addr = a; ren = 1'b1; wen = 1'b0;
    tick();
    ren = 1'b0;
    check_eq({tag, " rvalid"}, 64'(rvalid), 64'd1);
    check_eq({tag, " rdata"}, rdata, exp);
  endtask

  initial begin
    rst = 1'b1; wen = 1'b1; ren = 1'b0; addr = 8'd5;
    wdata = 64'hDEAD_BEEF_DEAD_BEEF; bwe = ONES;
    tick(); tick();
    // Reset state, even with a write request pending
    check_eq("reset ready", 64'(ready), 64'd1);
    check_eq("reset rvalid", 64'(rvalid), 64'd0);
    check_eq("reset rdata", rdata, 64'd0);
    check_eq("reset bank_cs", 64'(dut.bank_cs), 64'd0);
    wen = 1'b0;
    rst = 1'b0;
    tick();

    // Full write then read-back the next cycle
    do_write(8'd5, 64'h0123_4567_89AB_CDEF, ONES, "wr5");
    do_read(8'd5, 64'h0123_4567_89AB_CDEF, "rd5");
    tick();
    check_eq("hold rvalid", 64'(rvalid), 64'd0);
    check_eq("hold rdata", rdata, 64'h0123_4567_89AB_CDEF);

    // Same row in two banks, back-to-back full writes
    do_write(8'd3, 64'hAAAA_AAAA_AAAA_AAAA, ONES, "wr3");
    addr = 8'd131; wdata = 64'h5555_5555_5555_5555; bwe = ONES; wen = 1'b1;
    #1 check_eq("wr131 ready", 64'(ready), 64'd1);
    check_eq("wr131 bank_cs", 64'(dut.bank_cs), 64'd2);
    tick();
    wen = 1'b0;
    do_read(8'd3, 64'hAAAA_AAAA_AAAA_AAAA, "rd3");
    do_read(8'd131, 64'h5555_5555_5555_5555, "rd131");

    // wen+ren together is a write with no read return
    addr = 8'd7; wdata = 64'h11; bwe = ONES; wen = 1'b1; ren = 1'b1;
    tick();
    wen = 1'b0; ren = 1'b0;
    check_eq("wr+rd7 rvalid", 64'(rvalid), 64'd0);
    check_eq("wr+rd7 rdata hold", rdata, 64'h5555_5555_5555_5555);
    do_read(8'd7, 64'h11, "rd7");

    // Reset while a read result is being presented; contents survive
    do_write(8'd9, 64'h99, ONES, "wr9");
    do_read(8'd9, 64'h99, "rd9");
    rst = 1'b1;
    #1 check_eq("async rst rvalid", 64'(rvalid), 64'd0);
    check_eq("async rst rdata", rdata, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    do_read(8'd9, 64'h99, "rd9 post-rst");

`ifdef SRAM_SP_TILED_BWE_EN
    do_write(8'd6, 64'h66, ONES, "wr6");

    // Partial mask: RMW, ready low two cycles, inputs ignored meanwhile
    addr = 8'd5; wdata = ONES; bwe = 64'h0000_0000_FFFF_0000; wen = 1'b1;
    #1 check_eq("rmw5 ready at accept", 64'(ready), 64'd1);
    tick();
    addr = 8'd6; wdata = 64'd0; bwe = ONES; wen = 1'b1; ren = 1'b1;
    #1 check_eq("rmw5 ready c1", 64'(ready), 64'd0);
    check_eq("rmw5 rvalid c1", 64'(rvalid), 64'd0);
    tick();
    check_eq("rmw5 ready c2", 64'(ready), 64'd0);
    check_eq("rmw5 rvalid c2", 64'(rvalid), 64'd0);
    wen = 1'b0; ren = 1'b0;
    tick();
    check_eq("rmw5 ready c3", 64'(ready), 64'd1);
    check_eq("rmw5 rvalid c3", 64'(rvalid), 64'd0);
    do_read(8'd5, 64'h0123_4567_FFFF_CDEF, "rd5 after rmw");
    do_read(8'd6, 64'h66, "rd6 untouched");

    // All-zero mask is a no-op
    do_write(8'd5, 64'd0, 64'd0, "wr5 nomask");
    check_eq("nomask ready next", 64'(ready), 64'd1);
    do_read(8'd5, 64'h0123_4567_FFFF_CDEF, "rd5 after nomask");

    // Reset during RMW_RD aborts the sequence
    addr = 8'd10; wdata = 64'hFF; bwe = 64'hFF; wen = 1'b1;
    tick();
    wen = 1'b0;
    rst = 1'b1;
    #1 check_eq("rmw rst ready", 64'(ready), 64'd1);
    check_eq("rmw rst rvalid", 64'(rvalid), 64'd0);
    check_eq("rmw rst rdata", rdata, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("rmw rst ready after", 64'(ready), 64'd1);
    do_read(8'd9, 64'h99, "rd9 after rmw rst");
`else
    // Mask ignored: bwe=0 and partial bwe both write the full word
    do_write(8'd2, 64'h1234, 64'd0, "wr2 bwe0");
    check_eq("wr2 ready next", 64'(ready), 64'd1);
    do_read(8'd2, 64'h1234, "rd2");
    do_write(8'd4, 64'hDEAD_BEEF_0BAD_F00D, 64'hFF, "wr4 partial");
    check_eq("wr4 ready next", 64'(ready), 64'd1);
    do_read(8'd4, 64'hDEAD_BEEF_0BAD_F00D, "rd4");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
